// File: rtl/oc_detect.sv
// Over-current detector: offset removal, |x| magnitude, first-order IIR low-pass,
// hysteresis comparator with sample-count debounce, and a sample-stream watchdog.
module oc_detect #(
  parameter int unsigned DW      = 12,
  parameter int unsigned SHIFT   = 3,
  parameter int unsigned TH_HI   = 1000,
  parameter int unsigned TH_LO   = 600,
  parameter int unsigned DEB_ON  = 4,
  parameter int unsigned DEB_OFF = 16,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] offset,
  output logic          over_current,
  output logic [DW-1:0] filt,
  output logic          stale
);

  localparam int unsigned AW      = DW + SHIFT;
  localparam int unsigned DEB_MAX = (DEB_ON > DEB_OFF) ? DEB_ON : DEB_OFF;
  localparam int unsigned CW      = $clog2(DEB_MAX + 1);
  localparam int unsigned WW      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {NORMAL, ARMING, TRIPPED, RELEASING} state_e;

  logic signed [DW:0] diff_c;
  logic [DW:0]        abs_c;
  logic [DW-1:0]      mag_c;

  logic [AW-1:0] acc_q, acc_d;
  logic [DW-1:0] filt_q, filt_d;
  logic          fv_q, fv_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc_c;
  logic          hi_c, lo_c;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          stale_q, stale_d;
  logic          oc_q, oc_d;

  // Offset removal and saturated magnitude
  always_comb begin
    diff_c = $signed({1'b0, sample}) - $signed({1'b0, offset});
    abs_c  = diff_c[DW] ? $unsigned(-diff_c) : $unsigned(diff_c);
    mag_c  = abs_c[DW] ? '1 : abs_c[DW-1:0];
  end

  // IIR: acc tracks mag * 2^SHIFT, filt is the scaled-back value
  always_comb begin
    acc_d  = acc_q;
    filt_d = filt_q;
    fv_d   = sample_valid;
    if (sample_valid) begin
      acc_d  = acc_q - (acc_q >> SHIFT) + AW'(mag_c);
      filt_d = DW'(acc_d >> SHIFT);
    end
  end

  // Hysteresis/debounce FSM, evaluated once per freshly filtered sample
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_c      = (filt_q >= DW'(TH_HI));
    lo_c      = (filt_q <= DW'(TH_LO));
    cnt_inc_c = cnt_q + CW'(1);
    if (fv_q) begin
      unique case (state_q)
        NORMAL: begin
          if (hi_c) begin
            cnt_d   = CW'(1);
            state_d = (DEB_ON == 1) ? TRIPPED : ARMING;
          end
        end
        ARMING: begin
          if (hi_c) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CW'(DEB_ON)) state_d = TRIPPED;
          end else begin
            cnt_d   = '0;
            state_d = NORMAL;
          end
        end
        TRIPPED: begin
          if (lo_c) begin
            cnt_d   = CW'(1);
            state_d = (DEB_OFF == 1) ? NORMAL : RELEASING;
          end
        end
        RELEASING: begin
          if (lo_c) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CW'(DEB_OFF)) state_d = NORMAL;
          end else begin
            cnt_d   = '0;
            state_d = TRIPPED;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = NORMAL;
        end
      endcase
    end
  end

  // Watchdog: a strobe always wins over the terminal count
  always_comb begin
    wdog_d  = wdog_q;
    stale_d = stale_q;
    if (sample_valid) begin
      wdog_d  = '0;
      stale_d = 1'b0;
    end else if (wdog_q == WW'(TIMEOUT - 1)) begin
      stale_d = 1'b1;
    end else begin
      wdog_d = wdog_q + WW'(1);
    end
    oc_d = (state_d == TRIPPED) || (state_d == RELEASING) || stale_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      filt_q  <= '0;
      fv_q    <= 1'b0;
      state_q <= NORMAL;
      cnt_q   <= '0;
      wdog_q  <= '0;
      stale_q <= 1'b0;
      oc_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      filt_q  <= filt_d;
      fv_q    <= fv_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      stale_q <= stale_d;
      oc_q    <= oc_d;
    end
  end

  assign over_current = oc_q;
  assign filt         = filt_q;
  assign stale        = stale_q;

endmodule

// File: tb/tb_oc_detect.sv
// Directed bench for oc_detect: filter sequence, debounce, hysteresis, watchdog, reset.
module tb_oc_detect;

  localparam int unsigned GAP     = 100;
  localparam int unsigned TIMEOUT = 1000;  // shortened so the watchdog cases stay quick

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [11:0] sample;
  logic [11:0] offset;
  logic        over_current;
  logic [11:0] filt;
  logic        stale;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        rst_first;
    logic [11:0] smp;
    logic [11:0] off;
    logic [11:0] exp_filt;
    logic        exp_oc;
  } vec_t;

  vec_t vecs[$];

  oc_detect #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .offset       (offset),
    .over_current (over_current),
    .filt         (filt),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic void add(input bit r, input int s, input int o, input int f, input bit oc);
    vec_t v;
    v.rst_first = r;
    v.smp       = 12'(s);
    v.off       = 12'(o);
    v.exp_filt  = 12'(f);
    v.exp_oc    = oc;
    vecs.push_back(v);
  endfunction

  // One-cycle strobe; returns 1 ns after the capturing edge
  task automatic drive(input logic [11:0] s);
    @(negedge clk);
    sample_valid = 1'b1;
    sample       = s;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int step_f[9]  = '{250, 468, 660, 827, 974, 1102, 1214, 1313, 1399};
  int rel_a[22]  = '{1219, 1067, 933, 817, 714, 625, 547, 479, 419, 366, 321,
                     281, 245, 215, 188, 164, 144, 126, 110, 96, 84, 74};
  int rel_b1[7]  = '{1224, 1071, 937, 820, 717, 628, 549};
  int rel_b2[17] = '{639, 559, 489, 428, 375, 328, 287, 251, 220, 192, 168,
                     147, 129, 113, 99, 86, 75};

  initial begin
    logic prev_oc;
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    sample       = 12'd0;
    offset       = 12'd2048;

    // Table: step trip, negative current with glitch, release, release with re-trip
    for (int i = 0; i < 9; i++) add(i == 0, 4048, 2048, step_f[i], i == 8);
    for (int i = 0; i < 6; i++) add(i == 0, 48, 2048, step_f[i], 1'b0);
    add(1'b0, 2048, 2048, 964, 1'b0);
    add(1'b0, 48, 2048, 1094, 1'b0);
    add(1'b0, 48, 2048, 1207, 1'b0);
    add(1'b0, 48, 2048, 1306, 1'b0);
    add(1'b0, 48, 2048, 1393, 1'b1);
    for (int i = 0; i < 22; i++) add(1'b0, 2048, 2048, rel_a[i], i < 21);
    for (int i = 0; i < 9; i++) add(i == 0, 4048, 2048, step_f[i], i == 8);
    for (int i = 0; i < 7; i++) add(1'b0, 2048, 2048, rel_b1[i], 1'b1);
    add(1'b0, 4048, 2048, 730, 1'b1);
    for (int i = 0; i < 17; i++) add(1'b0, 2048, 2048, rel_b2[i], i < 16);

    // Asynchronous reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst over_current", over_current, 0);
    chk("rst filt", filt, 0);
    chk("rst stale", stale, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero current
    for (int i = 0; i < 50; i++) begin
      drive(12'd2048);
      chk($sformatf("zero%0d filt", i), filt, 0);
      tick(1);
      chk($sformatf("zero%0d oc", i), over_current, 0);
      chk($sformatf("zero%0d stale", i), stale, 0);
      tick(GAP - 2);
    end

    // Table-driven sequences; oc must lag filt by exactly one more clock
    prev_oc = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) begin
        do_reset();
        prev_oc = 1'b0;
      end
      offset = vecs[i].off;
      drive(vecs[i].smp);
      chk($sformatf("row%0d filt", i), filt, vecs[i].exp_filt);
      chk($sformatf("row%0d oc_early", i), over_current, prev_oc);
      tick(1);
      chk($sformatf("row%0d oc", i), over_current, vecs[i].exp_oc);
      tick(GAP - 2);
      prev_oc = vecs[i].exp_oc;
    end

    // Reset while tripped
    do_reset();
    offset = 12'd2048;
    for (int i = 0; i < 9; i++) begin
      drive(12'd4048);
      tick(1);
      if (i < 8) tick(GAP - 2);
    end
    chk("pre-reset oc", over_current, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst oc", over_current, 0);
    chk("midrst stale", stale, 0);
    chk("midrst filt", filt, 0);
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(12'd2048);
      chk($sformatf("postrst%0d filt", i), filt, 0);
      tick(1);
      chk($sformatf("postrst%0d oc", i), over_current, 0);
      tick(GAP - 2);
    end

    // Stale fail-safe: flags exactly TIMEOUT clocks after the last strobe
    drive(12'd2048);
    tick(TIMEOUT - 1);
    chk("stale early", stale, 0);
    chk("stale early oc", over_current, 0);
    tick(1);
    chk("stale set", stale, 1);
    chk("stale oc forced", over_current, 1);
    tick(5);
    chk("stale held", stale, 1);
    drive(12'd2048);
    chk("stale cleared", stale, 0);
    chk("stale clear oc", over_current, 0);
    tick(1);
    chk("after stale oc", over_current, 0);

    // Strobe coinciding with the terminal count keeps stale low
    tick(TIMEOUT - 2);
    drive(12'd2048);
    chk("tc+sample stale", stale, 0);
    chk("tc+sample oc", over_current, 0);
    tick(TIMEOUT - 1);
    chk("rearm early stale", stale, 0);
    tick(1);
    chk("rearm stale", stale, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oc_detect.md
Name: oc_detect

Overview:
- Over-current detector sitting directly upstream of the I2t thermal-protection stage.
- Consumes raw motor-current ADC samples with a valid strobe and removes the zero-current offset.
- Low-pass filters the magnitude and applies a hysteresis comparator with sample-count debounce.
- Drives the debounced over_current level into the I2t stage. A sample-stream watchdog forces over_current high if the ADC goes silent (fail-safe).

Parameters:
- DW, 12, ADC sample width.
- SHIFT, 3, IIR filter coefficient; alpha = 1/2^SHIFT.
- TH_HI, 1000, trip threshold on filt (inclusive, >=).
- TH_LO, 600, release threshold on filt (inclusive, <=); TH_LO < TH_HI required.
- DEB_ON, 4, consecutive filtered samples >= TH_HI needed to trip; >= 1.
- DEB_OFF, 16, consecutive filtered samples <= TH_LO needed to release; >= 1.
- TIMEOUT, 50000, clk cycles without sample_valid before stale is flagged.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- sample_valid  in  1  one-cycle strobe; sample is valid in this cycle
- sample  in  DW  unsigned ADC code
- offset  in  DW  zero-current ADC code; quasi-static
- over_current  out  1  debounced over-current level to the I2t stage
- filt  out  DW  filtered current magnitude (registered)
- stale  out  1  sample stream timed out

Behaviour:
- Reset: acc=0, filt=0, FSM=NORMAL, cnt=0, over_current=0, stale=0, wdog=0.
- Magnitude: mag = |sample - offset|.
  - Difference computed as DW+1-bit signed; absolute value saturated to 2^DW-1.
  - Example: sample 4095, offset 0 -> mag 4095.
- Filter: on sample_valid, acc <= acc - (acc>>SHIFT) + mag, with acc DW+SHIFT bits wide.
  - filt <= next acc >> SHIFT, registered on the same edge.
  - Steady-state acc cannot exceed (2^DW-1)*2^SHIFT, so no overflow is possible.
  - acc and filt are held when no sample is present.
- Pipeline:
  - Edge after sample_valid (N+1): filt updated; internal strobe fv=1 for one cycle.
  - FSM evaluates the new filt while fv=1.
  - over_current reflects that evaluation after edge N+2, i.e. 2-clk latency.
- FSM advances only on fv=1.
  - NORMAL: filt>=TH_HI -> cnt=1; goes to TRIPPED if DEB_ON==1, else ARMING. Otherwise stay.
  - ARMING: filt>=TH_HI -> cnt++; on reaching DEB_ON -> TRIPPED. filt<TH_HI -> NORMAL, cnt=0.
  - TRIPPED: filt<=TH_LO -> cnt=1; goes to NORMAL if DEB_OFF==1, else RELEASING. Otherwise stay.
  - RELEASING: filt<=TH_LO -> cnt++; on reaching DEB_OFF -> NORMAL. filt>TH_LO -> TRIPPED, cnt=0.
  - over_current (registered) = 1 in TRIPPED or RELEASING, or when stale=1.
- Watchdog:
  - wdog increments every clk and is cleared by sample_valid.
  - When wdog reaches TIMEOUT-1, stale <= 1 and wdog holds (saturates).
  - stale clears on the edge of the next sample_valid.
  - FSM, acc and cnt are untouched by staleness; only the output is forced.
- Simultaneous events: sample_valid in the same cycle as the watchdog terminal count means sample wins; stale stays 0.
- Back-to-back sample_valid on consecutive cycles is legal; each sample is processed through the pipeline.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). over_current drops to 0 with no debounce.

Test Plan:
- Zero current. Params at defaults. offset=2048, sample=2048 every 100 clk for 50 samples -> filt=0, over_current=0, stale=0 throughout.
- Step trip. offset=2048, sample=4048 (mag 2000) every 100 clk.
  - filt must read 250, 468, 660, 827, 974, 1102, ...
  - over_current stays 0 until exactly 2 clk after the 9th sample_valid, then becomes 1.
- Negative current and glitch rejection.
  - sample=48 (mag 2000) produces the same filt sequence as the step-trip case.
  - Injecting a single mag=0 sample before the 4th consecutive >=TH_HI result restarts the debounce -> no trip at the 9th sample.
- Release hysteresis. From TRIPPED, drop to mag=0 samples.
  - over_current stays 1 until the 16th consecutive filt<=600 sample, then goes 0 two clk later.
  - A single sample with filt in 601..999 during release returns the FSM to TRIPPED and restarts the count.
- Stale fail-safe. Stop sample_valid.
  - stale=1 and over_current=1 exactly TIMEOUT clk after the last strobe.
  - The next sample_valid clears stale on its edge.
  - over_current then reflects the FSM state (0 if NORMAL).
- Reset mid-trip. Assert rst_n=0 asynchronously while TRIPPED -> over_current, stale and filt go to 0 immediately. After release, 8 mag=0 samples keep over_current=0.
